// File: rtl/pet_pkg.sv
// Shared constants for the pet action scheduler.
// ST_COOL exists only when PET_COOLDOWN_EN is defined.
package pet_pkg;

    localparam int NUM_ACTIONS = 5;

    localparam logic [2:0] OP_DECAY = 3'd0;
    localparam logic [2:0] OP_FEED  = 3'd1;
    localparam logic [2:0] OP_PLAY  = 3'd2;
    localparam logic [2:0] OP_CLEAN = 3'd3;
    localparam logic [2:0] OP_SLEEP = 3'd4;
    localparam logic [2:0] OP_HEAL  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1
`ifdef PET_COOLDOWN_EN
        , ST_COOL = 2'd2
`endif
    } state_e;

    // First requesting action at or after ptr, wrapping; returns action index.
    function automatic logic [2:0] rr_pick(
        input logic [NUM_ACTIONS-1:0] req,
        input logic [2:0]             ptr
    );
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            idx = 3'((int'(ptr) + i) % NUM_ACTIONS);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Stat-decay prescaler: counts 0..TICK_COUNT-1 while enabled and
// pulses tick_o for one cycle on the last count.
module pet_tick_gen #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ena_i,
    output logic tick_o
);

    logic [23:0] cnt_q, cnt_d;

    assign tick_o = ena_i && (cnt_q == TICK_COUNT - 24'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (ena_i) begin
            cnt_d = tick_o ? 24'd0 : cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pet_action_sched.sv
// Pet action scheduler: latches request edges and decay ticks, then offers
// them one at a time to the stats datapath. PET_COOLDOWN_EN adds a lockout.
module pet_action_sched
    import pet_pkg::*;
#(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter logic [7:0]  COOLDOWN   = 8'd16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [NUM_ACTIONS-1:0] req_in,
    input  logic                   op_ready,
    output logic                   op_valid,
    output logic [2:0]             op_code,
    output logic [NUM_ACTIONS:0]   pending,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [2:0]             code_q, code_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [NUM_ACTIONS:0]   pend_q, pend_d;
    logic [NUM_ACTIONS-1:0] req_q;
    logic [NUM_ACTIONS-1:0] rise;
    logic                   tick;

`ifdef PET_COOLDOWN_EN
    logic [7:0] cool_q, cool_d;
`else
    logic unused_cooldown;
    assign unused_cooldown = ^COOLDOWN;
`endif

    pet_tick_gen #(
        .TICK_COUNT(TICK_COUNT)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(rst_n),
        .ena_i (ena),
        .tick_o(tick)
    );

    assign rise     = req_in & ~req_q;
    assign op_valid = (state_q == ST_OFFER);
    assign op_code  = code_q;
    assign pending  = pend_q;
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
`ifdef PET_COOLDOWN_EN
        cool_d  = cool_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (ena && (pend_q != '0)) begin
                    state_d = ST_OFFER;
                    code_d  = pend_q[0] ? OP_DECAY
                            : rr_pick(pend_q[NUM_ACTIONS:1], ptr_q) + 3'd1;
                end
            end
            ST_OFFER: begin
                if (op_ready) begin
                    pend_d[code_q] = 1'b0;
                    if (code_q == OP_DECAY) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Action index is code-1, so the next start is code mod 5.
                        ptr_d = (code_q == OP_HEAL) ? 3'd0 : code_q;
`ifdef PET_COOLDOWN_EN
                        if (COOLDOWN == 8'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_COOL;
                            cool_d  = COOLDOWN - 8'd1;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PET_COOLDOWN_EN
            ST_COOL: begin
                if (cool_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cool_d = cool_q - 8'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // New events win over the handshake clear.
        pend_d = pend_d | {rise, tick};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= OP_DECAY;
            ptr_q   <= 3'd0;
            pend_q  <= '0;
            req_q   <= '0;
`ifdef PET_COOLDOWN_EN
            cool_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            req_q   <= req_in;
`ifdef PET_COOLDOWN_EN
            cool_q  <= cool_d;
`endif
        end
    end

endmodule

// File: tb/tb_pet_action_sched.sv
// Self-checking bench for pet_action_sched (TICK_COUNT=8, COOLDOWN=4).
// Works with and without PET_COOLDOWN_EN.
module tb_pet_action_sched;

    localparam int TC = 8;
    localparam int CD = 4;
`ifdef PET_COOLDOWN_EN
    localparam bit COOL_EN = 1'b1;
`else
    localparam bit COOL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_v = 1'b0;
    logic [4:0] req_v = '0;
    logic       rdy_v = 1'b0;
    logic       op_valid;
    logic [2:0] op_code;
    logic [5:0] pending;
    logic       busy;

    pet_action_sched #(
        .TICK_COUNT(24'd8),
        .COOLDOWN  (8'd4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena_v),
        .req_in  (req_v),
        .op_ready(rdy_v),
        .op_valid(op_valid),
        .op_code (op_code),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hsq[$];

    // Reference model: pending set, one outstanding offer, lockout timer.
    logic [4:0] m_prev;
    logic [5:0] m_pend;
    int         m_ticks;
    bit         m_offer;
    int         m_code;
    int         m_cool;
    int         m_next;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_prev = '0; m_pend = '0; m_ticks = 0; m_offer = 0;
        m_code = 0;  m_cool = 0;  m_next = 0;
    endtask

    task automatic m_clock(input logic [4:0] r, input logic e, input logic y);
        logic [5:0] np;
        logic       tk;
        bit         found;
        int         a;
        tk = e && ((m_ticks % TC) == TC - 1);
        if (e) m_ticks++;
        np = m_pend;
        if (m_offer) begin
            if (y) begin
                np[m_code] = 1'b0;
                m_offer = 0;
                if (m_code != 0) begin
                    m_next = m_code % 5;
                    if (COOL_EN) m_cool = CD;
                end
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (e && m_pend != 0) begin
            m_offer = 1;
            if (m_pend[0]) m_code = 0;
            else begin
                found = 0;
                for (int i = 0; i < 5; i++) begin
                    a = (m_next + i) % 5;
                    if (!found && m_pend[a+1]) begin
                        m_code = a + 1;
                        found = 1;
                    end
                end
            end
        end
        np = np | {r & ~m_prev, tk};
        m_prev = r;
        m_pend = np;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_v = '0; ena_v = 1'b0; rdy_v = 1'b0;
        m_reset();
        hsq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [4:0] r, input logic e, input logic y);
        logic busy_e;
        req_v = r; ena_v = e; rdy_v = y;
        if (op_valid && y) hsq.push_back(int'(op_code));
        @(posedge clk);
        m_clock(r, e, y);
        #1;
        busy_e = m_offer || (m_cool > 0);
        check("model cycle", 32'({op_valid, op_code, pending, busy}),
              32'({m_offer, 3'(m_code), m_pend, busy_e}));
    endtask

    typedef struct {
        logic [4:0] req;
        logic       en;
        logic       rdy;
        logic       vld;
        logic [2:0] code;
        logic [5:0] pend;
        logic       bsy;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acts[$];
        int   exp_rr[3];
        int   feeds;
        logic [4:0] r;
        exp_rr = '{2, 3, 5};

        // Single FEED edge at cycle 10, then the first decay tick.
        for (int c = 0; c < 21; c++) begin
            tbl[c] = '{req: 5'b0, en: 1'b0, rdy: 1'b1, vld: 1'b0,
                       code: 3'd0, pend: 6'b0, bsy: 1'b0};
            if (c >= 10) begin
                tbl[c].req = 5'b00001;
                tbl[c].en  = 1'b1;
            end
            if (c >= 13 && c <= 18) tbl[c].code = 3'd1;
            if (c >= 13 && c <= 16) tbl[c].bsy = COOL_EN;
        end
        tbl[11].pend = 6'b000010;
        tbl[12].pend = 6'b000010; tbl[12].vld = 1'b1;
        tbl[12].code = 3'd1;      tbl[12].bsy = 1'b1;
        tbl[18].pend = 6'b000001;
        tbl[19].pend = 6'b000001; tbl[19].vld = 1'b1; tbl[19].bsy = 1'b1;

        do_reset();
        check("reset op_valid", 32'(op_valid), 32'd0);
        check("reset pending", 32'(pending), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset op_code", 32'(op_code), 32'd0);
        for (int c = 0; c < 21; c++) begin
            check($sformatf("tbl vld c%0d", c), 32'(op_valid), 32'(tbl[c].vld));
            check($sformatf("tbl code c%0d", c), 32'(op_code), 32'(tbl[c].code));
            check($sformatf("tbl pend c%0d", c), 32'(pending), 32'(tbl[c].pend));
            check($sformatf("tbl busy c%0d", c), 32'(busy), 32'(tbl[c].bsy));
            req_v = tbl[c].req; ena_v = tbl[c].en; rdy_v = tbl[c].rdy;
            @(posedge clk);
            #1;
        end

        // Simultaneous PLAY, CLEAN, HEAL: round-robin order.
        do_reset();
        for (int k = 0; k < 32; k++) step(5'b10110, 1'b1, 1'b1);
        acts.delete();
        foreach (hsq[i]) if (hsq[i] != 0) acts.push_back(hsq[i]);
        check("rr count", 32'(acts.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < acts.size()) check($sformatf("rr order %0d", i),
                                       32'(acts[i]), 32'(exp_rr[i]));

        // FEED edge coinciding with a decay tick: DECAY first.
        do_reset();
        while ((m_ticks % TC) != TC - 1) step(5'b0, 1'b1, 1'b1);
        step(5'b00001, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step(5'b00001, 1'b1, 1'b1);
        check("tick+feed count", 32'(hsq.size()), 32'd2);
        if (hsq.size() >= 2) begin
            check("tick+feed first", 32'(hsq[0]), 32'd0);
            check("tick+feed second", 32'(hsq[1]), 32'd1);
        end

        // Stalled offer survives ena dropping.
        do_reset();
        step(5'b00010, 1'b1, 1'b0);
        step(5'b00010, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check("stall valid", 32'(op_valid), 32'd1);
            check("stall code", 32'(op_code), 32'd2);
            step(5'b00010, (k < 5), 1'b0);
        end
        step(5'b00010, 1'b0, 1'b1);
        check("stall accepted", 32'(op_valid), 32'd0);
        check("stall pend clear", 32'(pending[2]), 32'd0);
        check("stall hs count", 32'(hsq.size()), 32'd1);

        // Reset in the middle of an offer.
        do_reset();
        step(5'b00001, 1'b1, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        check("pre-reset offer", 32'(op_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async valid", 32'(op_valid), 32'd0);
        check("async pending", 32'(pending), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(5'b0, 1'b1, 1'b1);
            check("post-reset idle", 32'(op_valid), 32'd0);
        end

        // Held FEED level issues exactly one FEED.
        do_reset();
        for (int k = 0; k < 50; k++) step(5'b00001, 1'b1, 1'b1);
        feeds = 0;
        foreach (hsq[i]) if (hsq[i] == 1) feeds++;
        check("held feed count", 32'(feeds), 32'd1);

        // Random traffic against the model.
        do_reset();
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            step(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pet_action_sched.md
PET_ACTION_SCHED -- requirements
Module: pet_action_sched

Interface
- REQ-001 SHALL have parameter TICK_COUNT, default 24'd10_000_000: stat-decay period in clk cycles.
- REQ-002 SHALL have parameter COOLDOWN, default 8'd16: post-action lockout in clk cycles.
- REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
- REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
- REQ-005 SHALL have port ena  input  1  high = design enabled; low freezes tick counter and blocks new grants.
- REQ-006 SHALL have port req_in  input  5  level action requests; bit0 FEED, bit1 PLAY, bit2 CLEAN, bit3 SLEEP, bit4 HEAL.
- REQ-007 SHALL have port op_ready  input  1  stats datapath accepts the offered op.
- REQ-008 SHALL have port op_valid  output  1  op offer to stats datapath.
- REQ-009 SHALL have port op_code  output  3  0 DECAY, 1 FEED, 2 PLAY, 3 CLEAN, 4 SLEEP, 5 HEAL; 6-7 never driven.
- REQ-010 SHALL have port pending  output  6  sticky pending bitmap; bit0 DECAY, bits1-5 actions.
- REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
- REQ-012 SHALL register req_in and set pending[i+1] only on a 0->1 edge of req_in[i]; held-high levels SHALL NOT re-set it.
- REQ-013 SHALL count the tick counter 0..TICK_COUNT-1 while ena=1, set pending[0] at TICK_COUNT-1, and wrap to 0.
- REQ-014 SHALL treat pending bits as sticky: a repeat event while set SHALL NOT queue a second op.
- REQ-015 SHALL implement FSM IDLE, OFFER, COOL; IDLE->OFFER when ena=1 and pending!=0.
- REQ-016 SHALL select the grant on the IDLE->OFFER edge: DECAY has fixed highest priority; actions round-robin starting after the last completed action.
- REQ-017 SHALL hold op_valid=1 and op_code stable in OFFER until op_valid&&op_ready; the offer SHALL NOT be retracted, even if ena falls.
- REQ-018 SHALL clear the granted pending bit in the handshake cycle and advance the round-robin pointer only on a completed action handshake.
- REQ-019 SHALL let set win over clear if a new edge for the granted source coincides with the handshake.
- REQ-020 SHALL, after handshake, go OFFER->COOL for actions and OFFER->IDLE for DECAY; COOL lasts COOLDOWN cycles, then IDLE.
- REQ-021 SHALL keep latching edges and ticks in COOL and OFFER.
- REQ-022 SHALL have latency: req_in edge in cycle n gives pending set in n+1 and op_valid=1 in n+2 from IDLE.

Reset
- REQ-023 SHALL, on rst_n=0, asynchronously force: state IDLE, op_valid 0, op_code 0, pending 0, busy 0, tick counter 0, cooldown counter 0, round-robin pointer at FEED, req_in history 0.
- REQ-024 SHALL discard any in-flight offer on reset mid-handshake; no op SHALL be reissued after release.

Configuration
- REQ-025 SHALL compile COOL state and COOLDOWN counter only when PET_COOLDOWN_EN is defined.
- REQ-026 SHALL, without PET_COOLDOWN_EN, go OFFER->IDLE after every handshake; COOLDOWN SHALL be ignored and the minimum gap between offers SHALL be 1 cycle.

Structure
- REQ-027 SHALL place op-code constants, FSM state encoding and NUM_ACTIONS=5 in shared package pet_pkg.
- REQ-028 SHALL implement the prescaler as sub-module pet_tick_gen, outputting a one-cycle pulse.

Verification (TICK_COUNT=8, COOLDOWN=4)
- REQ-029 SHALL test: req_in=5'b00001 rising at cycle 10, op_ready=1 -> op_valid=1, op_code=1 at cycle 12; pending[1] clear at 13; busy high 4 cycles in COOL.
- REQ-030 SHALL test: req_in=5'b10110 together, op_ready always 1 -> offers in order 2, 3, 5; each pending bit clears on its handshake.
- REQ-031 SHALL test: tick coinciding with a pending FEED -> op_code=0 offered first, then 1; DECAY followed by no COOL.
- REQ-032 SHALL test: op_ready=0 for 20 cycles and ena dropped at cycle 5 -> op_valid and op_code held; accepted when op_ready=1.
- REQ-033 SHALL test: rst_n low mid-OFFER -> op_valid=0 immediately, pending=0, and no offer after release until new edge.
- REQ-034 SHALL test: req_in[0] held high 50 cycles -> exactly one FEED op issued.
